// File: rtl/dsp_arith_pkg.sv
// Shared constants for the segmented pipelined add/subtract units in the DSP datapath.
package dsp_arith_pkg;

  // Segment split shared by the adder and the subtractor, LSB segment first.
  localparam int SEG_W0 = 9;
  localparam int SEG_W1 = 9;
  localparam int SEG_W2 = 9;
  localparam int SEG_W3 = 10;
  localparam int SEG_WIDTH = SEG_W0 + SEG_W1 + SEG_W2 + SEG_W3;

  localparam int ADD_LATENCY   = 5;
  localparam int SUB3P_LATENCY = ADD_LATENCY;

  typedef struct packed {
    logic lsbs_carry;
    logic middle_carry;
    logic msbs_carry;
  } seg_carry_pins_t;

endpackage

// File: rtl/sub3p_seg_carry_stage.sv
// One carry-ripple register: adds an incoming carry to a segment value and
// registers the result split into its low bits and its carry bit.
module seg_carry_stage #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W:0]   seg_i,
  input  logic         cin_i,
  output logic [W-1:0] lo_q,
  output logic         cy_q
);

  logic [W:0] sum_d;

  // seg_i[W] carries an already-resolved carry (MSB segment) or is 0.
  always_comb begin
    sum_d = seg_i + (W+1)'(cin_i);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lo_q <= '0;
      cy_q <= 1'b0;
    end else begin
      lo_q <= sum_d[W-1:0];
      cy_q <= sum_d[W];
    end
  end

endmodule

// File: rtl/sub3p.sv
// 37-bit pipelined subtractor: diff = x + ~y + 1 over four segments with staged
// carry ripple, plus valid tracking, unsigned borrow and signed overflow.
module sub3p
  import dsp_arith_pkg::*;
#(
  parameter int WIDTH  = SEG_WIDTH,
  parameter int WIDTH0 = SEG_W0,
  parameter int WIDTH1 = SEG_W1,
  parameter int WIDTH2 = SEG_W2,
  parameter int WIDTH3 = SEG_W3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] diff,
  output logic             out_valid,
  output logic             borrow,
  output logic             overflow,
  output logic             lsbs_carry,
  output logic             middle_carry,
  output logic             msbs_carry
);

  localparam int WIDTH01  = WIDTH0 + WIDTH1;
  localparam int WIDTH012 = WIDTH01 + WIDTH2;

  // Valid semantics: in_valid qualifies x/y on the sampling edge; out_valid
  // qualifies diff/borrow/overflow exactly SUB3P_LATENCY edges later. There is
  // no backpressure, so the pipeline advances every cycle.

  // Stage 0: input register, y inverted on the way in
  logic [WIDTH-1:0] x_q, ny_q;
  logic             vld0_q, xs0_q, ys0_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q    <= '0;
      ny_q   <= '0;
      vld0_q <= 1'b0;
      xs0_q  <= 1'b0;
      ys0_q  <= 1'b0;
    end else begin
      x_q    <= x;
      ny_q   <= ~y;
      vld0_q <= in_valid;
      xs0_q  <= x[WIDTH-1];
      ys0_q  <= y[WIDTH-1];
    end
  end

  // Stage 1: independent segment sums; the subtract's +1 enters segment 0
  logic [WIDTH0:0] q0_d, q0_q;
  logic [WIDTH1:0] q1_d, q1_q;
  logic [WIDTH2:0] q2_d, q2_q;
  logic [WIDTH3:0] q3_d, q3_q;
  logic            vld1_q, xs1_q, ys1_q;

  always_comb begin
    q0_d = {1'b0, x_q[WIDTH0-1:0]} + {1'b0, ny_q[WIDTH0-1:0]} + (WIDTH0+1)'(1);
    q1_d = {1'b0, x_q[WIDTH01-1:WIDTH0]} + {1'b0, ny_q[WIDTH01-1:WIDTH0]};
    q2_d = {1'b0, x_q[WIDTH012-1:WIDTH01]} + {1'b0, ny_q[WIDTH012-1:WIDTH01]};
    q3_d = {1'b0, x_q[WIDTH-1:WIDTH012]} + {1'b0, ny_q[WIDTH-1:WIDTH012]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q0_q   <= '0;
      q1_q   <= '0;
      q2_q   <= '0;
      q3_q   <= '0;
      vld1_q <= 1'b0;
      xs1_q  <= 1'b0;
      ys1_q  <= 1'b0;
    end else begin
      q0_q   <= q0_d;
      q1_q   <= q1_d;
      q2_q   <= q2_d;
      q3_q   <= q3_d;
      vld1_q <= vld0_q;
      xs1_q  <= xs0_q;
      ys1_q  <= ys0_q;
    end
  end

  // Stage 2: first carry ripple
  logic [WIDTH0-1:0] v0_q;
  logic [WIDTH1-1:0] v1_lo;
  logic [WIDTH2-1:0] v2_lo;
  logic [WIDTH3-1:0] v3_lo;
  logic              v1_cy, v2_cy, v3_cy;
  logic              vld2_q, xs2_q, ys2_q;

  seg_carry_stage #(.W(WIDTH1)) u_v1 (
    .clk(clk), .reset_n(reset_n),
    .seg_i({1'b0, q1_q[WIDTH1-1:0]}), .cin_i(q0_q[WIDTH0]),
    .lo_q(v1_lo), .cy_q(v1_cy)
  );

  seg_carry_stage #(.W(WIDTH2)) u_v2 (
    .clk(clk), .reset_n(reset_n),
    .seg_i({1'b0, q2_q[WIDTH2-1:0]}), .cin_i(q1_q[WIDTH1]),
    .lo_q(v2_lo), .cy_q(v2_cy)
  );

  // The MSB segment keeps its own carry bit; the final carry can never wrap.
  seg_carry_stage #(.W(WIDTH3)) u_v3 (
    .clk(clk), .reset_n(reset_n),
    .seg_i(q3_q), .cin_i(q2_q[WIDTH2]),
    .lo_q(v3_lo), .cy_q(v3_cy)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v0_q   <= '0;
      vld2_q <= 1'b0;
      xs2_q  <= 1'b0;
      ys2_q  <= 1'b0;
    end else begin
      v0_q   <= q0_q[WIDTH0-1:0];
      vld2_q <= vld1_q;
      xs2_q  <= xs1_q;
      ys2_q  <= ys1_q;
    end
  end

  // Stage 3: second carry ripple
  logic [WIDTH0-1:0] r0_q;
  logic [WIDTH1-1:0] r1_q;
  logic [WIDTH2-1:0] r2_lo;
  logic [WIDTH3-1:0] r3_lo;
  logic              r2_cy, r3_cy;
  logic              vld3_q, xs3_q, ys3_q;

  seg_carry_stage #(.W(WIDTH2)) u_r2 (
    .clk(clk), .reset_n(reset_n),
    .seg_i({1'b0, v2_lo}), .cin_i(v1_cy),
    .lo_q(r2_lo), .cy_q(r2_cy)
  );

  seg_carry_stage #(.W(WIDTH3)) u_r3 (
    .clk(clk), .reset_n(reset_n),
    .seg_i({v3_cy, v3_lo}), .cin_i(v2_cy),
    .lo_q(r3_lo), .cy_q(r3_cy)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r0_q   <= '0;
      r1_q   <= '0;
      vld3_q <= 1'b0;
      xs3_q  <= 1'b0;
      ys3_q  <= 1'b0;
    end else begin
      r0_q   <= v0_q;
      r1_q   <= v1_lo;
      vld3_q <= vld2_q;
      xs3_q  <= xs2_q;
      ys3_q  <= ys2_q;
    end
  end

  // Stage 4: last carry ripple, flags, and the registered outputs
  logic [WIDTH3:0]  s3_d;
  logic [WIDTH-1:0] diff_d, diff_q;
  logic             borrow_d, borrow_q;
  logic             overflow_d, overflow_q;
  logic             vld4_q;

  always_comb begin
    s3_d       = {r3_cy, r3_lo} + (WIDTH3+1)'(r2_cy);
    diff_d     = {s3_d[WIDTH3-1:0], r2_lo, r1_q, r0_q};
    borrow_d   = ~s3_d[WIDTH3];
    overflow_d = (xs3_q != ys3_q) & (diff_d[WIDTH-1] != xs3_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      vld4_q     <= 1'b0;
    end else begin
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
      vld4_q     <= vld3_q;
    end
  end

  seg_carry_pins_t pins;

  always_comb begin
    pins.lsbs_carry   = q0_q[WIDTH0];
    pins.middle_carry = v1_cy;
    pins.msbs_carry   = r2_cy;
  end

  assign diff         = diff_q;
  assign out_valid    = vld4_q;
  assign borrow       = borrow_q;
  assign overflow     = overflow_q;
  assign lsbs_carry   = pins.lsbs_carry;
  assign middle_carry = pins.middle_carry;
  assign msbs_carry   = pins.msbs_carry;

endmodule

// File: tb/tb_sub3p.sv
// Directed and streamed checks for sub3p: values, flags, latency, gaps and reset flush.
module tb_sub3p;

  localparam int W   = 37;
  localparam int LAT = 5;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic [W-1:0] x, y;
  logic [W-1:0] diff;
  logic         out_valid, borrow, overflow;
  logic         lsbs_carry, middle_carry, msbs_carry;

  sub3p dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .x(x), .y(y),
    .diff(diff), .out_valid(out_valid), .borrow(borrow), .overflow(overflow),
    .lsbs_carry(lsbs_carry), .middle_carry(middle_carry), .msbs_carry(msbs_carry)
  );

  // clock / cycle counter
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // scoreboard: {overflow, borrow, diff} plus the cycle each op was driven
  logic [W+1:0] exp_q[$];
  int           cyc_q[$];

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   full;
    logic [W-1:0] d;
    logic         ovf;
    full = {1'b0, a} - {1'b0, b};
    d    = full[W-1:0];
    ovf  = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
    return {ovf, full[W], d};
  endfunction

  // drive one cycle at the falling edge; valid ops enter the scoreboard
  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W+1:0] e);
    in_valid = v;
    x        = a;
    y        = b;
    if (v) begin
      exp_q.push_back(e);
      cyc_q.push_back(cyc);
    end
    @(negedge clk);
  endtask

  task automatic send_dir(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] d, input logic brw, input logic ovf);
    drive(1'b1, a, b, {ovf, brw, d});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0);
  endtask

  // monitor
  always @(negedge clk) begin
    logic [W+1:0] e;
    int           c;
    if (reset_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("stale_valid", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("diff", 64'(diff), 64'(e[W-1:0]));
        check("borrow", 64'(borrow), 64'(e[W]));
        check("overflow", 64'(overflow), 64'(e[W+1]));
        check("latency", 64'(cyc - c), 64'(LAT));
      end
    end
  end

  initial begin
    logic [W-1:0] a, b;
    logic         v;
    in_valid = 1'b0;
    x        = '0;
    y        = '0;
    reset_n  = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_diff", 64'(diff), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_borrow", 64'(borrow), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_lsbs_carry", 64'(lsbs_carry), 64'd0);
    check("rst_middle_carry", 64'(middle_carry), 64'd0);
    check("rst_msbs_carry", 64'(msbs_carry), 64'd0);

    reset_n = 1'b1;
    idle(2);

    // directed vectors
    send_dir(37'h00_0000_0000, 37'h00_0000_0001, 37'h1F_FFFF_FFFF, 1'b1, 1'b0);
    send_dir(37'h00_0000_0200, 37'h00_0000_0001, 37'h00_0000_01FF, 1'b0, 1'b0);
    send_dir(37'h00_0000_0001, 37'h00_0000_0001, 37'h00_0000_0000, 1'b0, 1'b0);
    check("lsbs_carry_0x200", 64'(lsbs_carry), 64'd0);
    send_dir(37'h10_0000_0000, 37'h00_0000_0001, 37'h0F_FFFF_FFFF, 1'b0, 1'b1);
    check("lsbs_carry_1m1", 64'(lsbs_carry), 64'd1);
    send_dir(37'h15_5555_5555, 37'h15_5555_5555, 37'h00_0000_0000, 1'b0, 1'b0);
    send_dir(37'h0F_FFFF_FFFF, 37'h1F_FFFF_FFFF, 37'h10_0000_0000, 1'b1, 1'b1);
    send_dir(37'h00_0000_0000, 37'h1F_FFFF_FFFF, 37'h00_0000_0001, 1'b1, 1'b0);
    send_dir(37'h1F_FFFF_FFFF, 37'h00_0000_0000, 37'h1F_FFFF_FFFF, 1'b0, 1'b0);
    send_dir(37'h00_0004_0000, 37'h00_0000_0001, 37'h00_0003_FFFF, 1'b0, 1'b0);
    idle(3);
    send_dir(37'h00_0800_0000, 37'h00_0000_0001, 37'h00_07FF_FFFF, 1'b0, 1'b0);

    // random stream with pseudo-random valid gaps
    for (int i = 0; i < 200; i++) begin
      a = W'({$urandom, $urandom});
      b = W'({$urandom, $urandom});
      v = 1'($urandom_range(0, 1));
      drive(v, a, b, model(a, b));
    end
    idle(0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    check("drain_stream", 64'(exp_q.size()), 64'd0);

    // reset with operations in flight
    for (int i = 0; i < 6; i++) begin
      a = W'({$urandom, $urandom});
      b = W'({$urandom, $urandom});
      drive(1'b1, a, b, model(a, b));
    end
    in_valid = 1'b0;
    #2;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_diff", 64'(diff), 64'd0);
    exp_q.delete();
    cyc_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);
    send_dir(37'h00_0000_0000, 37'h00_0000_0003, 37'h1F_FFFF_FFFD, 1'b1, 1'b0);
    idle(LAT + 3);
    check("drain_post_rst", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
